// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg
// Shared types and derivation helpers for the frame sequencer.
// Optional feature macro: FRAME_SEQ_PAD_EN. When it is defined, the last
// frame may run past the end of the buffer and is zero-filled.
package frame_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    STREAM,
    DRAIN
  } state_t;

`ifdef FRAME_SEQ_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  // With padding the frame count rounds up so the trailing samples get a frame.
  function automatic int calc_num_frames(input int total, input int flen,
                                         input int hop, input bit pad);
    if (pad) return (total - flen + hop - 1) / hop + 1;
    return (total - flen) / hop + 1;
  endfunction

  // Bits needed to index 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_aw(input int total);
    return width_of(total);
  endfunction

  function automatic int calc_nw(input int num_frames, input int flen);
    return width_of(num_frames * flen);
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// frame_addr_gen
// Frame-base accumulator plus in-frame position counter. The RAM address is
// kept as its own register (base + pos maintained incrementally), so no
// multiplier or wide adder sits in the address path.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clear          restart at frame 0 (base = 0, pos = 0)
//   step           advance one sample within the frame
//   advance        move to the next frame (base += HOP_LEN, pos = 0)
//   mem_addr       current RAM address
//   pos            current position inside the frame
//   in_range       current address lies inside the buffer
//   last           pos is the final sample of the frame
// Optional feature macro: FRAME_SEQ_PAD_EN (adds the range compare).
module frame_addr_gen import frame_seq_pkg::*; #(
  parameter int FRAME_LEN  = 1024,
  parameter int HOP_LEN    = 1024,
  parameter int TOTAL_DATA = 91136,
  parameter int AW         = calc_aw(TOTAL_DATA),
  parameter int PW         = width_of(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  input  logic          advance,
  output logic [AW-1:0] mem_addr,
  output logic [PW-1:0] pos,
  output logic          in_range,
  output logic          last
);

  // Padded frames can address up to almost 2*TOTAL_DATA, so one spare bit.
`ifdef FRAME_SEQ_PAD_EN
  localparam int XW = AW + 1;
`else
  localparam int XW = AW;
`endif

  logic [XW-1:0] base;
  logic [XW-1:0] addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base <= '0;
      addr <= '0;
      pos  <= '0;
    end else if (clear) begin
      base <= '0;
      addr <= '0;
      pos  <= '0;
    end else if (advance) begin
      base <= base + XW'(HOP_LEN);
      addr <= base + XW'(HOP_LEN);
      pos  <= '0;
    end else if (step) begin
      addr <= addr + XW'(1);
      pos  <= pos + PW'(1);
    end
  end

  assign mem_addr = addr[AW-1:0];
  assign last     = (pos == PW'(FRAME_LEN - 1));

`ifdef FRAME_SEQ_PAD_EN
  assign in_range = (addr < XW'(TOTAL_DATA));
`else
  // Every frame lies inside the buffer when the frame count rounds down.
  assign in_range = 1'b1;
`endif

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer
// Reads the captured sample buffer as a series of frames of FRAME_LEN
// samples spaced HOP_LEN apart and streams each frame to the windowing stage,
// waiting for win_ready before every frame.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start
// WAIT_RDY | frame armed, waiting for downstream win_ready
// STREAM   | issuing one RAM read per cycle for this frame
// DRAIN    | last read returning; next frame or finish
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start                one-cycle request to process the buffer
//   win_ready            downstream can take a whole frame
//   mem_rd_en, mem_addr  RAM read strobe and address
//   mem_rdata            RAM data, valid the cycle after mem_rd_en
//   win_data, win_num    sample and its global index (frame*FRAME_LEN+pos)
//   win_en               win_data / win_num valid
//   busy, done           run in progress / one-cycle completion pulse
//   frame_idx            current frame number
// Optional feature macro: FRAME_SEQ_PAD_EN (zero-filled final frame).
module frame_sequencer import frame_seq_pkg::*; #(
  parameter  int I_BW       = 14,
  parameter  int FRAME_LEN  = 1024,
  parameter  int HOP_LEN    = 1024,
  parameter  int TOTAL_DATA = 91136,
  localparam int NUM_FRAMES = calc_num_frames(TOTAL_DATA, FRAME_LEN, HOP_LEN, PAD_EN),
  localparam int AW         = calc_aw(TOTAL_DATA),
  localparam int NW         = calc_nw(NUM_FRAMES, FRAME_LEN),
  localparam int FW         = width_of(NUM_FRAMES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   win_ready,
  output logic                   mem_rd_en,
  output logic [AW-1:0]          mem_addr,
  input  logic signed [I_BW-1:0] mem_rdata,
  output logic signed [I_BW-1:0] win_data,
  output logic [NW-1:0]          win_num,
  output logic                   win_en,
  output logic                   busy,
  output logic                   done,
  output logic [FW-1:0]          frame_idx
);

  localparam int PW   = width_of(FRAME_LEN);
  localparam int LOG2 = $clog2(FRAME_LEN);

  state_t        state;
  logic          clear;
  logic          step;
  logic          advance;
  logic          last;
  logic          in_range;
  logic          last_frame;
  logic          rd_valid;
  logic [PW-1:0] pos;
  logic [NW-1:0] idx;

  frame_addr_gen #(
    .FRAME_LEN  (FRAME_LEN),
    .HOP_LEN    (HOP_LEN),
    .TOTAL_DATA (TOTAL_DATA),
    .AW         (AW),
    .PW         (PW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .step     (step),
    .advance  (advance),
    .mem_addr (mem_addr),
    .pos      (pos),
    .in_range (in_range),
    .last     (last)
  );

  assign last_frame = (frame_idx == FW'(NUM_FRAMES - 1));

  // done doubles as "just finished": a start coinciding with it is dropped.
  assign clear     = (state == IDLE) && start && !done;
  assign step      = (state == STREAM);
  assign advance   = (state == DRAIN) && !last_frame;
  assign mem_rd_en = step && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            state     <= WAIT_RDY;
            busy      <= 1'b1;
            frame_idx <= '0;
          end
        end
        WAIT_RDY: begin
          if (win_ready) state <= STREAM;
        end
        STREAM: begin
          if (last) state <= DRAIN;
        end
        DRAIN: begin
          if (last_frame) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            frame_idx <= frame_idx + FW'(1);
            state     <= WAIT_RDY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FRAME_LEN is a power of two, so the index is a plain bit placement.
  assign idx = (NW'(frame_idx) << LOG2) | NW'(pos);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_en   <= 1'b0;
      win_num  <= '0;
      rd_valid <= 1'b0;
    end else begin
      win_en   <= step;
      rd_valid <= mem_rd_en;
      if (step) win_num <= idx;
    end
  end

  // The RAM output is already the register stage; gating it by the delayed
  // read strobe zero-fills unread samples and drops data across a reset.
  assign win_data = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

  localparam int I_BW  = 14;
  localparam int FL    = 8;
  localparam int HOP_A = 4;
  localparam int TOT_A = 22;
  localparam int HOP_B = 8;
  localparam int TOT_B = 24;

`ifdef FRAME_SEQ_PAD_EN
  localparam int NF_A          = (TOT_A - FL + HOP_A - 1) / HOP_A + 1;
  localparam int NF_B          = (TOT_B - FL + HOP_B - 1) / HOP_B + 1;
  localparam int EXP_SAMPLES_A = 40;
  localparam int EXP_LAST_A    = 4;
`else
  localparam int NF_A          = (TOT_A - FL) / HOP_A + 1;
  localparam int NF_B          = (TOT_B - FL) / HOP_B + 1;
  localparam int EXP_SAMPLES_A = 32;
  localparam int EXP_LAST_A    = 3;
`endif

  localparam int AW_A = $clog2(TOT_A);
  localparam int NW_A = $clog2(NF_A * FL);
  localparam int FW_A = $clog2(NF_A + 1);
  localparam int AW_B = $clog2(TOT_B);
  localparam int NW_B = $clog2(NF_B * FL);
  localparam int FW_B = $clog2(NF_B + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                   a_start = 1'b0, a_ready = 1'b0;
  logic                   a_rd_en, a_win_en, a_busy, a_done;
  logic [AW_A-1:0]        a_addr;
  logic signed [I_BW-1:0] a_rdata = '0;
  logic signed [I_BW-1:0] a_win_data;
  logic [NW_A-1:0]        a_win_num;
  logic [FW_A-1:0]        a_frame_idx;

  logic                   b_start = 1'b0, b_ready = 1'b0;
  logic                   b_rd_en, b_win_en, b_busy, b_done;
  logic [AW_B-1:0]        b_addr;
  logic signed [I_BW-1:0] b_rdata = '0;
  logic signed [I_BW-1:0] b_win_data;
  logic [NW_B-1:0]        b_win_num;
  logic [FW_B-1:0]        b_frame_idx;

  frame_sequencer #(.I_BW(I_BW), .FRAME_LEN(FL), .HOP_LEN(HOP_A), .TOTAL_DATA(TOT_A)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .win_ready(a_ready),
    .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .win_data(a_win_data), .win_num(a_win_num), .win_en(a_win_en),
    .busy(a_busy), .done(a_done), .frame_idx(a_frame_idx)
  );

  frame_sequencer #(.I_BW(I_BW), .FRAME_LEN(FL), .HOP_LEN(HOP_B), .TOTAL_DATA(TOT_B)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .win_ready(b_ready),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .win_data(b_win_data), .win_num(b_win_num), .win_en(b_win_en),
    .busy(b_busy), .done(b_done), .frame_idx(b_frame_idx)
  );

  // Synchronous RAMs holding RAM[i] = i+1
  always @(posedge clk) begin
    if (a_rd_en) a_rdata <= I_BW'(int'(a_addr) + 1);
    if (b_rd_en) b_rdata <= I_BW'(int'(b_addr) + 1);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: the expected sample stream and read list
  typedef struct { int num; int data; } samp_t;
  samp_t exp_q[$];
  int    rd_q[$];

  task automatic load_model_a();
    samp_t s;
    exp_q.delete();
    rd_q.delete();
    for (int k = 0; k < NF_A; k++) begin
      for (int p = 0; p < FL; p++) begin
        int addr;
        addr   = k * HOP_A + p;
        s.num  = k * FL + p;
        s.data = (addr < TOT_A) ? addr + 1 : 0;
        exp_q.push_back(s);
        if (addr < TOT_A) rd_q.push_back(addr);
      end
    end
  endtask

  // Per-cycle compare process for instance A
  int run_len = 0, gap = 100, done_cnt = 0, win_cnt = 0;
  bit prev_en = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      run_len = 0;
      gap     = 100;
      prev_en = 1'b0;
    end else begin
      if (a_rd_en) begin
        check("rd_in_range", int'(int'(a_addr) < TOT_A), 1);
        if (rd_q.size() == 0) check("rd_unexpected", int'(a_addr), -1);
        else                  check("rd_addr", int'(a_addr), rd_q.pop_front());
      end
      if (a_win_en) begin
        samp_t s;
        if (run_len == 0 && gap < 100) check("frame_gap_ge2", int'(gap >= 2), 1);
        run_len++;
        gap = 0;
        win_cnt++;
        if (exp_q.size() == 0) check("win_unexpected", int'(a_win_num), -1);
        else begin
          s = exp_q.pop_front();
          check("win_num", int'(a_win_num), s.num);
          check("win_data", int'(a_win_data), s.data);
        end
      end else begin
        if (run_len > 0) check("frame_run_len", run_len, FL);
        run_len = 0;
        if (gap < 100) gap++;
        if (!a_busy) gap = 100;
      end
      if (a_done) begin
        done_cnt++;
        check("done_after_last_win_en", int'(prev_en), 1);
        check("busy_low_with_done", int'(a_busy), 0);
      end
      prev_en = a_win_en;
    end
  end

  task automatic check_a_zero(input string tag);
    check({tag, "_rd_en"},     int'(a_rd_en), 0);
    check({tag, "_addr"},      int'(a_addr), 0);
    check({tag, "_win_data"},  int'(a_win_data), 0);
    check({tag, "_win_num"},   int'(a_win_num), 0);
    check({tag, "_win_en"},    int'(a_win_en), 0);
    check({tag, "_busy"},      int'(a_busy), 0);
    check({tag, "_done"},      int'(a_done), 0);
    check({tag, "_frame_idx"}, int'(a_frame_idx), 0);
  endtask

  task automatic wait_done_a(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (a_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_a_seen", int'(ok), 1);
  endtask

  // Full run with win_ready held high, including start/done latency pins
  task automatic run_basic_a(input string tag);
    int d0, w0;
    load_model_a();
    d0 = done_cnt;
    w0 = win_cnt;
    a_ready = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check({tag, "_busy_t1"}, int'(a_busy), 1);
    check({tag, "_rd_en_t1"}, int'(a_rd_en), 0);
    @(negedge clk);
    check({tag, "_rd_en_t2"}, int'(a_rd_en), 1);
    check({tag, "_addr_t2"}, int'(a_addr), 0);
    @(negedge clk);
    check({tag, "_win_en_t3"}, int'(a_win_en), 1);
    check({tag, "_win_num_t3"}, int'(a_win_num), 0);
    check({tag, "_win_data_t3"}, int'(a_win_data), 1);
    wait_done_a(300);
    check({tag, "_last_frame_idx"}, int'(a_frame_idx), EXP_LAST_A);
    // start coinciding with done must be ignored
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    check({tag, "_start_at_done_ignored"}, int'(a_busy), 0);
    check({tag, "_samples"}, win_cnt - w0, EXP_SAMPLES_A);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_model_drained"}, exp_q.size() + rd_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, n_idx, r_idx;
    bit ok;

    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset_b_busy", int'(b_busy), 0);
    rst = 1'b1;
    @(negedge clk);

    // Baseline
    run_basic_a("base");

    // Ready gating before frame 2, plus start pulsed while busy
    load_model_a();
    d0 = done_cnt;
    w0 = win_cnt;
    a_ready = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (int'(a_frame_idx) == 1) && a_rd_en;
    end
    check("gate_reached_frame1", int'(ok), 1);
    a_start = 1'b1;
    a_ready = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    ok = (int'(a_frame_idx) == 2);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (int'(a_frame_idx) == 2);
    end
    check("gate_reached_frame2", int'(ok), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("gate_no_read_while_not_ready", int'(a_rd_en), 0);
    end
    a_ready = 1'b1;
    @(negedge clk);
    check("gate_rd_en_after_ready", int'(a_rd_en), 1);
    check("gate_frame2_addr", int'(a_addr), 8);
    @(negedge clk);
    check("gate_frame2_win_en", int'(a_win_en), 1);
    check("gate_frame2_win_num", int'(a_win_num), 16);
    check("gate_frame2_win_data", int'(a_win_data), 9);
    wait_done_a(300);
    @(negedge clk);
    check("gate_samples", win_cnt - w0, EXP_SAMPLES_A);
    check("gate_done_count", done_cnt - d0, 1);
    check("gate_model_drained", exp_q.size() + rd_q.size(), 0);

    // Reset during frame 2, sample 3
    load_model_a();
    d0 = done_cnt;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      @(negedge clk);
      ok = (int'(a_frame_idx) == 2) && a_rd_en && (int'(a_addr) == 11);
    end
    check("rstmid_reached", int'(ok), 1);
    rst = 1'b0;
    #1;
    check_a_zero("rstmid");
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    check_a_zero("rstmid_hold");
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_idle", int'(a_busy), 0);

    // Restart after reset runs from frame 0
    run_basic_a("rerun");

    // Non-overlapping instance: win_num equals address, data = address+1
    n_idx = 0;
    r_idx = 0;
    ok = 1'b0;
    b_ready = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (b_rd_en) begin
        check("nov_addr", int'(b_addr), r_idx);
        r_idx++;
      end
      if (b_win_en) begin
        check("nov_win_num", int'(b_win_num), n_idx);
        check("nov_win_data", int'(b_win_data), n_idx + 1);
        n_idx++;
      end
      ok = b_done;
    end
    check("nov_done", int'(ok), 1);
    check("nov_samples", n_idx, 24);
    check("nov_reads", r_idx, 24);
    check("nov_last_frame_idx", int'(b_frame_idx), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
